// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select generator and load-use stall detector.
// Optional saturating hazard statistics are built when HAZ_STATS_EN is defined.

module fwd_sel_lane #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  used,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    output logic [1:0]            sel
);
    logic ex_hit;
    logic mem_hit;

    // A load in EX is never a forwarding source: that case stalls instead.
    assign ex_hit  = ex_valid && ex_reg_write && !ex_mem_read && (ex_rd == rs);
    assign mem_hit = mem_valid && mem_reg_write && (mem_rd == rs);

    always_comb begin
        sel = 2'b01;
        if (!used || rs == '0)
            sel = 2'b01;
        else if (ex_hit)
            sel = 2'b10;
        else if (mem_hit)
            sel = 2'b11;
    end
endmodule

module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      fwd_count
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } slot_t;

    slot_t ex_q, mem_q, wb_q, ex_d;

    logic [NUM_OPS-1:0][REG_ADDR_W-1:0] op_rs;
    logic [NUM_OPS-1:0]                 op_used;
    logic [NUM_OPS-1:0]                 op_load_hit;
    logic [NUM_OPS-1:0][1:0]            sel_comb;
    logic [NUM_OPS-1:0][1:0]            sel_nxt;
    logic [NUM_OPS-1:0][1:0]            sel_q;
    logic                               bubble;
    logic                               load_in_ex;

    assign op_rs   = {id_rs2, id_rs1};
    assign op_used = {id_rs2_used, id_rs1_used};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        fwd_sel_lane #(.REG_ADDR_W(REG_ADDR_W)) u_lane (
            .rs            (op_rs[g]),
            .used          (op_used[g]),
            .ex_valid      (ex_q.valid),
            .ex_rd         (ex_q.rd),
            .ex_reg_write  (ex_q.reg_write),
            .ex_mem_read   (ex_q.mem_read),
            .mem_valid     (mem_q.valid),
            .mem_rd        (mem_q.rd),
            .mem_reg_write (mem_q.reg_write),
            .sel           (sel_comb[g])
        );
        assign op_load_hit[g] = op_used[g] && (op_rs[g] == ex_q.rd);
    end

    assign load_in_ex = ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.rd != '0);
    // flush wins over the hazard: the squashed instruction needs no data.
    assign stall      = id_valid && !flush && load_in_ex && (|op_load_hit);
    assign bubble     = flush || stall || !id_valid;

    always_comb begin
        ex_d           = '0;
        sel_nxt        = {NUM_OPS{2'b01}};
        if (!bubble) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            sel_nxt        = sel_comb;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            sel_q <= {NUM_OPS{2'b01}};
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            sel_q <= sel_nxt;
        end
    end

    assign fwd_sel_a = sel_q[0];
    assign fwd_sel_b = sel_q[1];

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_q;
    logic [1:0]       fwd_inc;
    logic [CNT_W:0]   fwd_sum;

    assign fwd_inc = {1'b0, (sel_nxt[0] != 2'b01)} + {1'b0, (sel_nxt[1] != 2'b01)};
    assign fwd_sum = {1'b0, fwd_cnt_q} + {{(CNT_W-1){1'b0}}, fwd_inc};

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            // Carry out of the add means we crossed all-ones: pin there.
            fwd_cnt_q <= fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
        end
    end

    assign stall_count = stall_cnt_q;
    assign fwd_count   = fwd_cnt_q;
`else
    assign stall_count = '0;
    assign fwd_count   = '0;
`endif

    // WB slot and MEM load flag are kept for debug visibility only.
    logic unused_dbg;
    assign unused_dbg = ^{wb_q, mem_q.mem_read};

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Forwarding and load-use hazard controller for the pipelined core's EX-stage operand muxes, which are 3-input muxes with 2-bit selects.
- Tracks destination-register tags of in-flight instructions through internal EX/MEM/WB tag slots.
- Produces registered forwarding selects for operands A and B, aligned with the instruction in EX.
- Raises a stall on load-use hazards.
- Sits beside the ID/EX pipeline register; its inputs come from ID-stage decode.

Parameters:
REG_ADDR_W, 5, width of register specifiers (x0 hard-wired zero)
CNT_W, 32, width of statistics counters (used only with HAZ_STATS_EN)

Ports:
clk  input  1  core clock, rising edge
arst_n  input  1  reset, synchronous, active-low, sampled on rising clk
id_valid  input  1  valid instruction in ID
id_rs1  input  REG_ADDR_W  source register 1 of ID instruction
id_rs2  input  REG_ADDR_W  source register 2 of ID instruction
id_rs1_used  input  1  instruction reads rs1
id_rs2_used  input  1  instruction reads rs2
id_rd  input  REG_ADDR_W  destination register of ID instruction
id_reg_write  input  1  instruction writes rd
id_mem_read  input  1  instruction is a load
flush  input  1  branch/jump redirect; squash instruction leaving ID
stall  output  1  hold PC and IF/ID, insert bubble into EX (combinational)
fwd_sel_a  output  2  EX operand A mux select, registered
fwd_sel_b  output  2  EX operand B mux select, registered
stall_count  output  CNT_W  stall cycles (HAZ_STATS_EN only)
fwd_count  output  CNT_W  forwarded operands (HAZ_STATS_EN only)

Behaviour:
- Select encoding:
  - 2'b01 = register-file operand.
  - 2'b10 = EX/MEM ALU result.
  - 2'b11 = MEM/WB writeback value.
  - 2'b00 is never driven.
- Tag slots EX, MEM, WB each hold {valid, rd, reg_write, mem_read}.
- Every cycle, MEM<=EX and WB<=MEM, unconditionally.
- EX slot load:
  - If flush, or stall, or !id_valid: EX<=bubble (valid=0).
  - Otherwise EX<=ID fields with valid=1.
- stall = id_valid & !flush & EX.valid & EX.mem_read & EX.reg_write & (EX.rd!=0) & ((id_rs1_used & id_rs1==EX.rd) | (id_rs2_used & id_rs2==EX.rd)).
  - Combinational from inputs and EX slot.
  - Asserts for exactly one cycle per load-use hazard. Upstream holds ID, so the re-presented instruction then matches the load in MEM and is forwarded 11.
- Select computation, per operand, evaluated in the cycle the instruction leaves ID; result registered so it is valid while the instruction is in EX (latency 1):
  - Operand unused, or rs==0: select 01.
  - Else if current EX slot valid, reg_write, rd==rs, !mem_read: select 10. Youngest producer wins.
  - Else if current MEM slot valid, reg_write, rd==rs: select 11.
  - Else: select 01.
- When EX is loaded with a bubble (stall/flush/!id_valid), both selects register 01.
- Register file is write-first: a WB-slot producer needs no forwarding; the controller ignores the WB slot for selects. The WB slot exists only for stats/debug visibility.
- flush has priority over stall. Flush and a hazard in the same cycle give stall=0 and an EX bubble.
- Reset (arst_n=0 at a clk edge): all slots invalid, fwd_sel_a=fwd_sel_b=01, counters 0. stall reads 0 from the next cycle, since EX is invalid.
- Reset mid-hazard cancels the stall; no pending state survives.

Optional Feature:
- Macro HAZ_STATS_EN.
- Defined:
  - stall_count increments each cycle stall=1.
  - fwd_count adds the number of non-01 selects registered that cycle (0, 1 or 2).
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- ALU dependency: add x5 (cycle n), add using rs1=x5 (n+1) -> fwd_sel_a=10 at n+2, fwd_sel_b=01.
- Distance-2 dependency: writer x6, an independent instruction, reader rs2=x6 -> fwd_sel_b=11 in the reader's EX cycle.
- Double producer: two writes to x7 back-to-back, then a reader rs1=x7 -> select 10, not 11 (youngest wins).
- Load-use: lw x8, then add rs1=x8 -> stall=1 for exactly one cycle, EX bubble with selects 01, then fwd_sel_a=11. With HAZ_STATS_EN: stall_count=1, fwd_count=1.
- x0 and flush: writer x0 then reader x0 -> select 01. A load-use hazard coincident with flush=1 -> stall=0 and EX bubble.
- Reset mid-hazard: arst_n=0 during a stall cycle -> next cycle stall=0, selects 01, counters 0.
